alu_seq_unit: RTL
=================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of 2, >= 8).
REQ-002 SHALL have parameter WIDTH_INSTRUC, default 32, instruction width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port instruccion  input  WIDTH_INSTRUC  instruction word; funct3=[14:12], funct7=[31:25].
REQ-008 SHALL have port ALU_OP  input  2  main-decoder op class.
REQ-009 SHALL have ports op_a, op_b  input  WIDTH  operands.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have port alu_inst  output  4  registered decoded op code of the held result.
REQ-014 SHALL have port zero  output  1  registered flag, 1 when result == 0.
REQ-015 SHALL have port busy  output  1  high in MUL state.

Function
REQ-016 SHALL decode: ALU_OP 00 -> add 0010; 01 -> sub 0110; 11 -> add 0010.
REQ-017 SHALL decode ALU_OP 10 by funct7/funct3: 0000000/000 add 0010; 0100000/000 sub 0110; 0000000/111 and 0000; 0000000/110 or 0001; 0000000/100 xor 0011; 0000000/001 sll 0100; 0000000/101 srl 0101; 0100000/101 sra 0111; 0000000/010 slt 1000; 0000000/011 sltu 1001; 0000001/000 mul 1010.
REQ-018 SHALL decode every other ALU_OP 10 combination to add 0010; decode fully combinational, no latches.
REQ-019 SHALL use op_b[$clog2(WIDTH)-1:0] as shift amount; sra sign-fills from op_a[WIDTH-1].
REQ-020 SHALL compute slt signed and sltu unsigned, result 1 or 0 zero-extended to WIDTH.
REQ-021 SHALL wrap add/sub modulo 2^WIDTH; mul returns low WIDTH bits of the product.
REQ-022 SHALL implement FSM states IDLE, MUL, DONE.
REQ-023 IDLE: in_ready=1; on in_valid, latch decode and operands; non-mul -> compute, register result/zero/alu_inst, go DONE; mul -> go MUL, counter=0.
REQ-024 MUL: iterative shift-and-add, one multiplier bit per cycle, exactly WIDTH cycles, then register result/zero/alu_inst and go DONE.
REQ-025 DONE: out_valid=1; on out_ready go IDLE; else hold result, zero, alu_inst stable.
REQ-026 in_ready SHALL be 0 in MUL and DONE; in_valid and operands ignored there.
REQ-027 Latency: non-mul accepted at edge N -> out_valid high after edge N+1... i.e. from edge N (one cycle); mul -> out_valid after edge N+WIDTH.
REQ-028 No new request SHALL be accepted in the cycle out_valid&&out_ready completes; next acceptance earliest the following cycle.
REQ-029 out_valid SHALL be 0 in IDLE and MUL.

Reset
REQ-030 rst high SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, result=0, alu_inst=0010, zero=1, counter=0.
REQ-031 rst mid-MUL or in DONE SHALL discard the operation; no out_valid for it after release.

Verification
REQ-032 ALU_OP=10, funct7=0100000, funct3=000, op_a=5, op_b=7 -> one cycle later out_valid=1, result=32'hFFFFFFFE, alu_inst=0110, zero=0.
REQ-033 ALU_OP=10, funct7=0000001, funct3=000, op_a=12345, op_b=678 (WIDTH=32) -> busy for 32 cycles, then result=8369910, alu_inst=1010; in_ready=0 throughout.
REQ-034 ALU_OP=10, funct7=0100000, funct3=101, op_a=32'h80000000, op_b=4 -> result=32'hF8000000; same with funct7=0 (srl) -> 32'h08000000.
REQ-035 Result in DONE with out_ready=0 for 5 cycles -> result, alu_inst, out_valid stable; in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-036 ALU_OP=10, funct7=0000000, funct3=010, op_a=-1, op_b=1 -> result=1; funct3=011 -> result=0, zero=1.
REQ-037 rst asserted at MUL cycle 10 -> outputs at reset values asynchronously; after release, new add 3+4 -> result=7.

Source files
------------

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle ops plus a WIDTH-cycle shift-and-add multiply,
// with a valid/ready handshake on both the request and the held result.
module alu_seq_unit #(
  parameter int WIDTH         = 32,
  parameter int WIDTH_INSTRUC = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH_INSTRUC-1:0] instruccion,
  input  logic [1:0]               ALU_OP,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic [3:0]               alu_inst,
  output logic                     zero,
  output logic                     busy
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [3:0]       r_alu_inst;

  logic [6:0]       w_f7;
  logic [2:0]       w_f3;
  logic [3:0]       w_r_dec;
  logic [3:0]       w_dec;
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_last;
  logic             w_is_mul;
  logic             w_unused;

  assign w_f7     = instruccion[31:25];
  assign w_f3     = instruccion[14:12];
  assign w_unused = ^{instruccion[24:15], instruccion[11:0]};
  assign w_sh     = op_b[SW-1:0];

  // R-type table; anything not listed falls back to add
  always_comb begin
    w_r_dec = OP_ADD;
    case ({w_f7, w_f3})
      10'b0000000_000: w_r_dec = OP_ADD;
      10'b0100000_000: w_r_dec = OP_SUB;
      10'b0000000_111: w_r_dec = OP_AND;
      10'b0000000_110: w_r_dec = OP_OR;
      10'b0000000_100: w_r_dec = OP_XOR;
      10'b0000000_001: w_r_dec = OP_SLL;
      10'b0000000_101: w_r_dec = OP_SRL;
      10'b0100000_101: w_r_dec = OP_SRA;
      10'b0000000_010: w_r_dec = OP_SLT;
      10'b0000000_011: w_r_dec = OP_SLTU;
      10'b0000001_000: w_r_dec = OP_MUL;
      default:         w_r_dec = OP_ADD;
    endcase
  end

  always_comb begin
    w_dec = OP_ADD;
    unique case (1'b1)
      (ALU_OP == 2'b01): w_dec = OP_SUB;
      (ALU_OP == 2'b10): w_dec = w_r_dec;
      default:           w_dec = OP_ADD;
    endcase
  end

  assign w_is_mul = (w_dec == OP_MUL);

  always_comb begin
    w_res = op_a + op_b;
    case (w_dec)
      OP_SUB:  w_res = op_a - op_b;
      OP_AND:  w_res = op_a & op_b;
      OP_OR:   w_res = op_a | op_b;
      OP_XOR:  w_res = op_a ^ op_b;
      OP_SLL:  w_res = op_a << w_sh;
      OP_SRL:  w_res = op_a >> w_sh;
      OP_SRA:  w_res = WIDTH'($signed(op_a) >>> w_sh);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      default: w_res = op_a + op_b;
    endcase
  end

  // r_a shifts up, r_b shifts down: one multiplier bit consumed per cycle
  assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
  assign w_last    = (r_cnt == SW'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = w_is_mul ? S_MUL : S_DONE;
      S_MUL:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_alu_inst <= OP_ADD;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && w_is_mul) begin
            r_a   <= op_a;
            r_b   <= op_b;
            r_acc <= '0;
            r_cnt <= '0;
          end else if (in_valid) begin
            r_result   <= w_res;
            r_zero     <= (w_res == '0);
            r_alu_inst <= w_dec;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + SW'(1);
          if (w_last) begin
            r_result   <= w_acc_nxt;
            r_zero     <= (w_acc_nxt == '0);
            r_alu_inst <= OP_MUL;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_MUL);
  assign result    = r_result;
  assign zero      = r_zero;
  assign alu_inst  = r_alu_inst;

endmodule
